// File: rtl/lc3b_mem_arbiter.sv
// Arbitrates the single pmem port between the I-fetch and D requesters.
// One latched transaction at a time. Ties are broken round-robin on the last D grant.
module lc3b_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,

  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,

  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  // state    | meaning
  // ST_IDLE  | no strobes; pick a requester and latch its request
  // ST_SERVE_I | pmem_read for the latched I request until pmem_resp
  // ST_SERVE_D | pmem_read/pmem_write for the latched D request until pmem_resp
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVE_I = 2'd1,
    ST_SERVE_D = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_last_d;
  logic                r_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [LINE_W-1:0]   r_wdata;

  logic                w_i_pend;
  logic                w_d_pend;
  logic                w_grant_i;
  logic                w_grant_d;

  assign w_i_pend = i_read;
  assign w_d_pend = d_read | d_write;

  always_comb begin
    w_next     = r_state;
    w_grant_i  = 1'b0;
    w_grant_d  = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_i_pend && w_d_pend) begin
          w_grant_i = r_last_d;
          w_grant_d = ~r_last_d;
        end else begin
          w_grant_i = w_i_pend;
          w_grant_d = w_d_pend;
        end
        if (w_grant_i) begin
          w_next = ST_SERVE_I;
        end else if (w_grant_d) begin
          w_next = ST_SERVE_D;
        end
      end
      ST_SERVE_I: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          i_resp = 1'b1;
          w_next = ST_IDLE;
        end
      end
      ST_SERVE_D: begin
        pmem_read  = ~r_write;
        pmem_write = r_write;
        if (pmem_resp) begin
          d_resp = 1'b1;
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A simultaneous d_read/d_write latches as a write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
    end else if (w_grant_i) begin
      r_addr  <= i_address;
      r_wdata <= '0;
      r_write <= 1'b0;
    end else if (w_grant_d) begin
      r_addr  <= d_address;
      r_wdata <= d_wdata;
      r_write <= d_write;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_d <= 1'b0;
    end else if (i_resp) begin
      r_last_d <= 1'b0;
    end else if (d_resp) begin
      r_last_d <= 1'b1;
    end
  end

  assign pmem_address = r_addr;
  assign pmem_wdata   = r_wdata;
  assign i_rdata      = pmem_rdata;
  assign d_rdata      = pmem_rdata;

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Self-checking bench for lc3b_mem_arbiter: directed vector table, hand sequences
// for tie/reset corners, and a random run against a transaction-level model.
module tb_lc3b_mem_arbiter;

  logic         clk;
  logic         reset;
  logic         i_read;
  logic [15:0]  i_address;
  logic [127:0] i_rdata;
  logic         i_resp;
  logic         d_read;
  logic         d_write;
  logic [15:0]  d_address;
  logic [127:0] d_wdata;
  logic [127:0] d_rdata;
  logic         d_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  int checks;
  int failures;

  lc3b_mem_arbiter #(.ADDR_W(16), .LINE_W(128)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         i_rd;
    logic [15:0]  i_a;
    logic         d_rd;
    logic         d_wr;
    logic [15:0]  d_a;
    logic [127:0] d_wd;
    logic         resp;
    logic         e_rd;
    logic         e_wr;
    logic [15:0]  e_a;
    logic         e_ir;
    logic         e_dr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic ird, logic [15:0] ia, logic drd, logic dwr,
                              logic [15:0] da, logic [127:0] wd, logic rsp,
                              logic erd, logic ewr, logic [15:0] ea,
                              logic eir, logic edr);
    vec_t v;
    v.i_rd = ird; v.i_a = ia; v.d_rd = drd; v.d_wr = dwr; v.d_a = da;
    v.d_wd = wd; v.resp = rsp; v.e_rd = erd; v.e_wr = ewr; v.e_a = ea;
    v.e_ir = eir; v.e_dr = edr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One cycle: drive just after the rising edge, return at the falling edge.
  task automatic drive(input logic ird, input logic [15:0] ia, input logic drd,
                       input logic dwr, input logic [15:0] da, input logic [127:0] wd,
                       input logic rsp);
    @(posedge clk);
    #1;
    i_read     = ird;
    i_address  = ia;
    d_read     = drd;
    d_write    = dwr;
    d_address  = da;
    d_wdata    = wd;
    pmem_resp  = rsp;
    pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    i_read    = 1'b0;
    d_read    = 1'b0;
    d_write   = 1'b0;
    pmem_resp = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Transaction-level reference: who owns the port and the request it was given.
  int           m_owner;   // 0 none, 1 I, 2 D
  logic [15:0]  m_addr;
  logic [127:0] m_wdata;
  logic         m_is_wr;
  logic         m_last_d;

  task automatic model_reset();
    m_owner = 0; m_addr = '0; m_wdata = '0; m_is_wr = 1'b0; m_last_d = 1'b0;
  endtask

  task automatic model_advance();
    bit want_i, want_d;
    want_i = i_read;
    want_d = d_read || d_write;
    if (m_owner == 0) begin
      if (want_i && (!want_d || m_last_d)) begin
        m_owner = 1; m_addr = i_address; m_is_wr = 1'b0;
      end else if (want_d) begin
        m_owner = 2; m_addr = d_address; m_wdata = d_wdata; m_is_wr = d_write;
      end
    end else if (pmem_resp) begin
      m_last_d = (m_owner == 2);
      m_owner  = 0;
    end
  endtask

  localparam logic [127:0] W1 = {8{16'hBEEF}};
  localparam logic [127:0] W2 = {4{32'hCAFE_0123}};

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    i_read = 1'b0; i_address = '0; d_read = 1'b0; d_write = 1'b0;
    d_address = '0; d_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;

    // ---------------- directed vector table ----------------
    tbl.push_back(mk(1, 16'h1230, 0, 0, 16'h0, '0, 0,  0, 0, 16'h0000, 0, 0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(1, 16'h1230, 0, 0, 16'h0, '0, 0,  1, 0, 16'h1230, 0, 0));
    tbl.push_back(mk(1, 16'h1230, 0, 0, 16'h0, '0, 1,  1, 0, 16'h1230, 1, 0));
    tbl.push_back(mk(0, 16'h0,    0, 0, 16'h0, '0, 0,  0, 0, 16'h1230, 0, 0));
    tbl.push_back(mk(0, 16'h0,    0, 1, 16'h4000, W1, 0,  0, 0, 16'h1230, 0, 0));
    tbl.push_back(mk(0, 16'h0,    0, 1, 16'h4000, W1, 0,  0, 1, 16'h4000, 0, 0));
    tbl.push_back(mk(0, 16'h0,    0, 1, 16'h4000, W1, 1,  0, 1, 16'h4000, 0, 1));
    tbl.push_back(mk(0, 16'h0,    0, 0, 16'h0, '0, 0,  0, 0, 16'h4000, 0, 0));
    tbl.push_back(mk(1, 16'h2000, 1, 0, 16'h3000, '0, 0,  0, 0, 16'h4000, 0, 0));
    tbl.push_back(mk(1, 16'h2000, 1, 0, 16'h3000, '0, 0,  1, 0, 16'h2000, 0, 0));
    tbl.push_back(mk(1, 16'h2000, 1, 0, 16'h3000, '0, 1,  1, 0, 16'h2000, 1, 0));
    tbl.push_back(mk(0, 16'h2000, 1, 0, 16'h3000, '0, 0,  0, 0, 16'h2000, 0, 0));
    tbl.push_back(mk(1, 16'h5000, 1, 0, 16'h3000, '0, 0,  1, 0, 16'h3000, 0, 0));
    tbl.push_back(mk(1, 16'h5000, 1, 0, 16'h3000, '0, 1,  1, 0, 16'h3000, 0, 1));
    tbl.push_back(mk(1, 16'h5000, 0, 0, 16'h3000, '0, 0,  0, 0, 16'h3000, 0, 0));
    tbl.push_back(mk(1, 16'h5000, 0, 0, 16'h3000, '0, 1,  1, 0, 16'h5000, 1, 0));
    tbl.push_back(mk(0, 16'h0,    0, 0, 16'h0, '0, 1,  0, 0, 16'h5000, 0, 0));
    tbl.push_back(mk(0, 16'h0,    1, 1, 16'h6000, W2, 0,  0, 0, 16'h5000, 0, 0));
    tbl.push_back(mk(0, 16'h0,    1, 1, 16'h6000, W2, 1,  0, 1, 16'h6000, 0, 1));
    tbl.push_back(mk(0, 16'h0,    0, 0, 16'h0, '0, 0,  0, 0, 16'h6000, 0, 0));

    // Reset values are checked asynchronously while reset is still asserted.
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_pmem_read",  pmem_read, 1'b0);
    chk("rst_pmem_write", pmem_write, 1'b0);
    chk("rst_address",    pmem_address, 16'h0);
    chk("rst_wdata",      pmem_wdata, '0);
    chk("rst_resp",       {i_resp, d_resp}, 2'b00);
    do_reset();

    foreach (tbl[n]) begin
      drive(tbl[n].i_rd, tbl[n].i_a, tbl[n].d_rd, tbl[n].d_wr, tbl[n].d_a,
            tbl[n].d_wd, tbl[n].resp);
      chk($sformatf("vec%0d_pmem_read", n),  pmem_read,  tbl[n].e_rd);
      chk($sformatf("vec%0d_pmem_write", n), pmem_write, tbl[n].e_wr);
      chk($sformatf("vec%0d_address", n),    pmem_address, tbl[n].e_a);
      chk($sformatf("vec%0d_i_resp", n),     i_resp, tbl[n].e_ir);
      chk($sformatf("vec%0d_d_resp", n),     d_resp, tbl[n].e_dr);
      if (tbl[n].e_wr)
        chk($sformatf("vec%0d_wdata", n), pmem_wdata, tbl[n].d_wd);
      if (tbl[n].e_ir)
        chk($sformatf("vec%0d_i_rdata", n), i_rdata, pmem_rdata);
      if (tbl[n].e_dr)
        chk($sformatf("vec%0d_d_rdata", n), d_rdata, pmem_rdata);
    end

    // ---------------- tie after reset: D, then I, then D ----------------
    do_reset();
    drive(1, 16'hA000, 1, 0, 16'hB000, '0, 0);
    chk("tie_idle_strobe", {pmem_read, pmem_write}, 2'b00);
    drive(1, 16'hA000, 1, 0, 16'hB000, '0, 0);
    chk("tie1_grant_d_addr", pmem_address, 16'hB000);
    drive(1, 16'hA000, 1, 0, 16'hB000, '0, 1);
    chk("tie1_resp", {i_resp, d_resp}, 2'b01);
    drive(1, 16'hA000, 0, 0, 16'h0, '0, 0);
    chk("tie_gap_idle", {pmem_read, pmem_write, i_resp, d_resp}, 4'b0000);
    drive(1, 16'hA000, 0, 0, 16'h0, '0, 1);
    chk("tie2_grant_i_addr", pmem_address, 16'hA000);
    chk("tie2_resp", {i_resp, d_resp}, 2'b10);
    drive(1, 16'hA100, 1, 0, 16'hB100, '0, 0);
    drive(1, 16'hA100, 1, 0, 16'hB100, '0, 0);
    chk("tie3_grant_d_addr", pmem_address, 16'hB100);
    chk("tie3_strobe", {pmem_read, pmem_write}, 2'b10);
    drive(0, 16'h0, 0, 0, 16'h0, '0, 1);
    chk("tie3_resp", {i_resp, d_resp}, 2'b01);

    // ---------------- reset in the middle of a D write ----------------
    drive(0, 16'h0, 0, 1, 16'h7000, W1, 0);
    drive(0, 16'h0, 0, 1, 16'h7000, W1, 0);
    chk("mid_write_active", pmem_write, 1'b1);
    #2;
    reset = 1'b1;
    d_write = 1'b0;
    #1;
    chk("mid_rst_strobes", {pmem_read, pmem_write}, 2'b00);
    chk("mid_rst_address", pmem_address, 16'h0);
    chk("mid_rst_wdata",   pmem_wdata, '0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(0, 16'h0, 0, 0, 16'h0, '0, 1);
      chk($sformatf("late_resp%0d", k),
          {pmem_read, pmem_write, i_resp, d_resp}, 4'b0000);
    end

    // ---------------- randomized against the reference model ----------------
    do_reset();
    model_reset();
    for (int c = 0; c < 2000; c++) begin
      drive(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 2) == 0), 16'($urandom),
            {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 3) == 0));
      chk("rnd_pmem_read",  pmem_read,
          (m_owner == 1) || (m_owner == 2 && !m_is_wr));
      chk("rnd_pmem_write", pmem_write, (m_owner == 2) && m_is_wr);
      chk("rnd_address",    pmem_address, m_addr);
      chk("rnd_i_resp",     i_resp, (m_owner == 1) && pmem_resp);
      chk("rnd_d_resp",     d_resp, (m_owner == 2) && pmem_resp);
      if (m_owner == 2)
        chk("rnd_wdata", pmem_wdata, m_wdata);
      chk("rnd_rdata", {i_rdata, d_rdata}, {pmem_rdata, pmem_rdata});
      model_advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
